instr_dispatch_fsm: RTL and testbench
=====================================

// Module: instr_dispatch_fsm
// PURPOSE
//   Parametrised instruction fetch/decode/dispatch controller for the accelerator top level.
//   Runs a program of prog_len instructions from instruction memory and requests a DDR refill when the memory is empty.
//   Routes each instruction to one of NUM_UNITS execution units using the opcode select field, waits for that unit's completion, then advances.
//   Adds multi-unit routing, valid/ready dispatch, program end, an execution timeout, abort and error reporting.
// PARAMETERS
//   INSTR_W    64  instruction width
//   ADDR_W     10  instruction memory address width
//   NUM_UNITS  4   number of execution units (1..2**SEL_W-1)
//   SEL_W      3   unit-select field width, taken from instr[INSTR_W-1 -: SEL_W]
//   TIMEOUT    0   max cycles spent in EXEC; 0 disables the timeout
// PORTS
//   clk            in   1          clock; all logic is on the rising edge
//   rst_n          in   1          asynchronous active-low reset
//   start          in   1          run request, sampled in IDLE or ERR
//   abort          in   1          abandon the current program
//   prog_len       in   ADDR_W+1   number of instructions, latched on start
//   imem_empty     in   1          instruction memory holds no valid program
//   imem_fill_req  out  1          DDR refill request (level)
//   imem_fill_done in   1          refill complete
//   imem_addr      out  ADDR_W     read address (equals pc)
//   imem_rd_en     out  1          read strobe; data arrives 1 cycle later
//   imem_rdata     in   INSTR_W    read data
//   instr_out      out  INSTR_W    registered instruction to units
//   instr_valid    out  NUM_UNITS  one-hot dispatch valid
//   unit_ready     in   NUM_UNITS  per-unit accept
//   unit_done      in   NUM_UNITS  per-unit completion pulse
//   busy           out  1          high in every state except IDLE and ERR
//   done           out  1          1-cycle pulse at normal program end
//   error          out  1          sticky error flag
//   err_code       out  2          01 = illegal select, 10 = timeout
//   pc             out  ADDR_W     current instruction index
// BEHAVIOUR
//   Reset: all outputs, pc, instr_out, err_code and timers = 0; state = IDLE.
//   States: IDLE, FILL, READ, WAIT, DECODE, DISPATCH, EXEC, FINISH, ERR.
//   - IDLE/ERR on start:
//       clear error and err_code; pc=0; latch prog_len.
//       len==0 -> FINISH; imem_empty -> FILL; else -> READ.
//   - FILL: imem_fill_req=1 until imem_fill_done is seen; clear the request that same edge; -> READ.
//   - READ: imem_rd_en=1 for exactly one cycle with imem_addr=pc; -> WAIT.
//   - WAIT: register imem_rdata into instr_out; -> DECODE.
//   - DECODE: sel = instr_out[INSTR_W-1 -: SEL_W].
//       sel == all-ones -> FINISH (end-of-program marker; pc does not advance).
//       sel < NUM_UNITS -> DISPATCH.
//       otherwise -> ERR with err_code=01.
//   - DISPATCH:
//       instr_valid[sel]=1; instr_out is held stable.
//       Transfer on instr_valid[sel] & unit_ready[sel]; valid drops the next cycle; -> EXEC.
//   - EXEC:
//       Sample only unit_done[sel]; other units' done bits are ignored.
//       A done pulse in the transfer cycle is not counted.
//       On done: pc+1.
//         pc+1 == latched len -> FINISH.
//         imem_empty -> FILL.
//         else -> READ.
//       TIMEOUT != 0 and the EXEC cycle count reaches TIMEOUT -> ERR with err_code=10.
//   - FINISH: done=1 for one cycle; -> IDLE.
//   - ERR: error=1 is held; busy=0; leave only via start or reset.
//   Abort:
//     Any state other than IDLE/ERR -> IDLE next cycle.
//     Clears instr_valid and imem_fill_req; no done pulse; error unchanged.
//     Abort has priority over every other event, including a simultaneous start.
//   start while busy is ignored.
//   Best-case per-instruction latency (ready and done immediate): READ -> next READ = 5 cycles.
//   pc never wraps: the program ends at len; len up to 2**ADDR_W is legal.
// TESTING
//   - len=3, imem not empty, units 0/1/2, ready=1, done 2 cycles after accept:
//       3 one-hot dispatches, addr 0,1,2, done pulse, busy=0.
//   - imem_empty=1 at start, fill_done after 10 cycles:
//       fill_req high exactly 10 cycles, first rd_en on the next READ.
//   - Instruction sel=3'b111 at pc=1 of len=4:
//       done after 1 dispatch, pc=1, no valid for the marker.
//   - sel=5 with NUM_UNITS=4:
//       error=1, err_code=01, no instr_valid.
//     Then start:
//       error clears and the program runs.
//   - TIMEOUT=8, unit never done:
//       ERR with err_code=10 after 8 EXEC cycles.
//   - abort asserted mid-DISPATCH with ready=0:
//       valid drops, IDLE next cycle, no done.
//   - Reset asserted mid-EXEC:
//       all outputs 0 immediately (async).

Source files
------------

// File: rtl/instr_dispatch_if.sv
// Bundle of the controller's run-control, instruction-memory and execution-unit signals.
// master = the dispatch controller, slave = the environment (memory, units, host).
interface instr_dispatch_if #(
    parameter int INSTR_W   = 64,
    parameter int ADDR_W    = 10,
    parameter int NUM_UNITS = 4
);
    logic                 start;
    logic                 abort;
    logic [ADDR_W:0]      prog_len;
    logic                 imem_empty;
    logic                 imem_fill_req;
    logic                 imem_fill_done;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 imem_rd_en;
    logic [INSTR_W-1:0]   imem_rdata;
    logic [INSTR_W-1:0]   instr_out;
    // Dispatch handshake: instr_valid[k] stays high with instr_out stable until
    // the rising edge where unit_ready[k] is also high; that edge is the transfer.
    logic [NUM_UNITS-1:0] instr_valid;
    logic [NUM_UNITS-1:0] unit_ready;
    logic [NUM_UNITS-1:0] unit_done;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [1:0]           err_code;
    logic [ADDR_W-1:0]    pc;
    logic [3:0]           dbg_state;

    modport master (
        input  start, abort, prog_len, imem_empty, imem_fill_done, imem_rdata,
               unit_ready, unit_done,
        output imem_fill_req, imem_addr, imem_rd_en, instr_out, instr_valid,
               busy, done, error, err_code, pc, dbg_state
    );

    modport slave (
        output start, abort, prog_len, imem_empty, imem_fill_done, imem_rdata,
               unit_ready, unit_done,
        input  imem_fill_req, imem_addr, imem_rd_en, instr_out, instr_valid,
               busy, done, error, err_code, pc, dbg_state
    );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Instruction fetch/decode/dispatch controller: reads a program from instruction
// memory, routes each instruction to the selected execution unit and waits for it.
module instr_dispatch_fsm #(
    parameter int INSTR_W   = 64,
    parameter int ADDR_W    = 10,
    parameter int NUM_UNITS = 4,
    parameter int SEL_W     = 3,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_dispatch_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_READ, S_WAIT, S_DECODE,
        S_DISPATCH, S_EXEC, S_FINISH, S_ERR
    } state_e;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SEL_W-1:0] SEL_END = '1;

    state_e               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [ADDR_W:0]      len_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [NUM_UNITS-1:0] sel_oh_q;
    logic [NUM_UNITS-1:0] valid_q;
    logic                 fill_req_q;
    logic                 rd_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [1:0]           err_code_q;
    logic [TW-1:0]        timer_q;

    logic [SEL_W-1:0]     sel_d;
    logic [ADDR_W:0]      pc_inc_d;

    assign sel_d    = instr_q[INSTR_W-1 -: SEL_W];
    assign pc_inc_d = {1'b0, pc_q} + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            instr_q    <= '0;
            sel_oh_q   <= '0;
            valid_q    <= '0;
            fill_req_q <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            timer_q    <= '0;
        end else begin
            done_q <= 1'b0;
            // Abort wins over everything while a program is in flight; error is left alone.
            if (bus.abort && state_q != S_IDLE && state_q != S_ERR) begin
                state_q    <= S_IDLE;
                valid_q    <= '0;
                fill_req_q <= 1'b0;
                rd_en_q    <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_ERR: begin
                        if (bus.start && !bus.abort) begin
                            error_q    <= 1'b0;
                            err_code_q <= 2'b00;
                            pc_q       <= '0;
                            len_q      <= bus.prog_len;
                            busy_q     <= 1'b1;
                            if (bus.prog_len == '0) begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end else if (bus.imem_empty) begin
                                state_q    <= S_FILL;
                                fill_req_q <= 1'b1;
                            end else begin
                                state_q <= S_READ;
                                rd_en_q <= 1'b1;
                            end
                        end
                    end
                    S_FILL: begin
                        if (bus.imem_fill_done) begin
                            fill_req_q <= 1'b0;
                            rd_en_q    <= 1'b1;
                            state_q    <= S_READ;
                        end
                    end
                    S_READ: begin
                        rd_en_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        instr_q <= bus.imem_rdata;
                        state_q <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (sel_d == SEL_END) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else if (32'(sel_d) < 32'(NUM_UNITS)) begin
                            valid_q  <= NUM_UNITS'(1) << sel_d;
                            sel_oh_q <= NUM_UNITS'(1) << sel_d;
                            state_q  <= S_DISPATCH;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= 2'b01;
                            busy_q     <= 1'b0;
                            state_q    <= S_ERR;
                        end
                    end
                    S_DISPATCH: begin
                        if (|(valid_q & bus.unit_ready)) begin
                            valid_q <= '0;
                            timer_q <= '0;
                            state_q <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (|(sel_oh_q & bus.unit_done)) begin
                            if (pc_inc_d == len_q) begin
                                // A full 2**ADDR_W program would overflow pc, so it stays on the last index.
                                if (!pc_inc_d[ADDR_W]) pc_q <= pc_inc_d[ADDR_W-1:0];
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                pc_q <= pc_inc_d[ADDR_W-1:0];
                                if (bus.imem_empty) begin
                                    state_q    <= S_FILL;
                                    fill_req_q <= 1'b1;
                                end else begin
                                    state_q <= S_READ;
                                    rd_en_q <= 1'b1;
                                end
                            end
                        end else if (TIMEOUT != 0 && int'(timer_q) == TIMEOUT - 1) begin
                            error_q    <= 1'b1;
                            err_code_q <= 2'b10;
                            busy_q     <= 1'b0;
                            state_q    <= S_ERR;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.imem_fill_req = fill_req_q;
    assign bus.imem_addr     = pc_q;
    assign bus.imem_rd_en    = rd_en_q;
    assign bus.instr_out     = instr_q;
    assign bus.instr_valid   = valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.err_code      = err_code_q;
    assign bus.pc            = pc_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Bench for instr_dispatch_fsm: memory and unit models, a program-level reference
// model with expected queues, directed corner cases and randomized programs.
module tb_instr_dispatch_fsm;
    localparam int INSTR_W   = 64;
    localparam int ADDR_W    = 10;
    localparam int NUM_UNITS = 4;
    localparam int SEL_W     = 3;
    localparam int TIMEOUT   = 8;
    localparam int BUDGET    = 2000;

    localparam int MODE_NORMAL  = 0;
    localparam int MODE_NO_DONE = 1;
    localparam int MODE_ABORT   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [INSTR_W-1:0] exp_q[$];
    int                 addr_q[$];
    int                 exp_pc;
    logic               exp_err;
    logic [1:0]         exp_code;

    instr_dispatch_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_UNITS(NUM_UNITS)) bus();

    instr_dispatch_fsm #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_UNITS(NUM_UNITS),
        .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / memory model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk_instr(input int sel);
        logic [INSTR_W-1:0] v;
        v = {$urandom(), $urandom()};
        v[INSTR_W-1 -: SEL_W] = SEL_W'(sel);
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_error"},    bus.error, 0);
        check({tag, "_err_code"}, bus.err_code, 0);
        check({tag, "_pc"},       bus.pc, 0);
        check({tag, "_instr"},    bus.instr_out, 0);
        check({tag, "_valid"},    bus.instr_valid, 0);
        check({tag, "_rd_en"},    bus.imem_rd_en, 0);
        check({tag, "_fill_req"}, bus.imem_fill_req, 0);
    endtask

    // Reference model: walk the program by its rules and list what must happen.
    task automatic build_model(input int len, input int mode);
        int s;
        exp_q.delete();
        addr_q.delete();
        exp_err  = 1'b0;
        exp_code = 2'b00;
        exp_pc   = len;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(i);
            s = int'(mem[i][INSTR_W-1 -: SEL_W]);
            if (s == (1 << SEL_W) - 1) begin
                exp_pc = i;
                break;
            end
            if (s >= NUM_UNITS) begin
                exp_err = 1'b1; exp_code = 2'b01; exp_pc = i;
                break;
            end
            exp_q.push_back(mem[i]);
            if (mode == MODE_NO_DONE) begin
                exp_err = 1'b1; exp_code = 2'b10; exp_pc = i;
                break;
            end
        end
    endtask

    // Driver + unit/fill responder + scoreboard for one program run.
    task automatic run_prog(input int len, input bit empty, input int fill_lat, input int mode);
        int cyc = 0, ph = 0, rdy_wait, done_wait = 0, exec_cnt = 0, n_xfer = 0;
        int fill_cnt = 0, exp_fills, done_seen = 0, vcyc = 0, cur_sel = 0, exp_a;
        bit finished = 0, prev_rd = 0, prev_fill = 0;
        logic [INSTR_W-1:0]   exp_i;
        logic [NUM_UNITS-1:0] oh_cur = '0;

        build_model(len, mode);
        exp_fills = (empty && len > 0) ? 1 : 0;
        rdy_wait  = $urandom_range(0, 2);
        bus.prog_len   = (ADDR_W+1)'(len);
        bus.imem_empty = empty;
        bus.start      = 1'b1;
        while (!finished && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.start     = 1'b0;
            bus.unit_done = '0;
            if (bus.done) begin
                done_seen++;
                finished = 1;
            end
            if (bus.error) begin
                if (mode == MODE_NO_DONE) check("timeout_cycles", exec_cnt, TIMEOUT);
                check("err_busy", bus.busy, 0);
                finished = 1;
            end
            if (bus.imem_rd_en) begin
                check("rd_pulse", prev_rd, 0);
                exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                check("rd_addr", bus.imem_addr, exp_a);
            end
            if (prev_fill && !bus.imem_fill_req && mode != MODE_ABORT)
                check("rd_after_fill", bus.imem_rd_en, 1);
            prev_rd   = bus.imem_rd_en;
            prev_fill = bus.imem_fill_req;
            if (bus.imem_fill_req) begin
                fill_cnt++;
                bus.imem_fill_done = (fill_cnt % fill_lat == 0);
                if (bus.imem_fill_done) bus.imem_empty = 1'b0;
            end else begin
                bus.imem_fill_done = 1'b0;
            end

            case (ph)
                0: begin
                    bus.unit_ready = '0;
                    if (|bus.instr_valid) begin
                        exp_i   = (exp_q.size() > 0) ? exp_q[0] : '1;
                        cur_sel = int'(exp_i[INSTR_W-1 -: SEL_W]);
                        oh_cur  = NUM_UNITS'(1) << cur_sel;
                        check("valid_onehot", bus.instr_valid, oh_cur);
                        check("instr_out", bus.instr_out, exp_i);
                        if (mode == MODE_ABORT) begin
                            vcyc++;
                            if (vcyc == 2) begin
                                bus.abort = 1'b1;
                                ph = 3;
                            end
                        end else if (rdy_wait == 0) begin
                            bus.unit_ready = oh_cur;
                            if ($urandom_range(0, 1) == 1) bus.unit_done = oh_cur;
                            ph = 1;
                        end else begin
                            rdy_wait--;
                        end
                    end
                end
                1: begin
                    check("valid_drop", bus.instr_valid, 0);
                    bus.unit_ready = '0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    n_xfer++;
                    if (mode == MODE_NO_DONE) begin
                        ph = 4;
                        exec_cnt = 1;
                    end else begin
                        ph = 2;
                        done_wait = $urandom_range(0, 4);
                    end
                end
                3: begin
                    check("abort_valid", bus.instr_valid, 0);
                    check("abort_busy", bus.busy, 0);
                    check("abort_fill", bus.imem_fill_req, 0);
                    bus.abort = 1'b0;
                    finished  = 1;
                end
                4: if (!bus.error) exec_cnt++;
                default: ;
            endcase

            if (ph == 2) begin
                bus.unit_done = NUM_UNITS'($urandom_range(0, 15)) & ~oh_cur;
                if (done_wait == 0) begin
                    bus.unit_done = bus.unit_done | oh_cur;
                    if (n_xfer != len && $urandom_range(0, 3) == 0) begin
                        bus.imem_empty = 1'b1;
                        exp_fills++;
                    end
                    ph = 0;
                    rdy_wait = $urandom_range(0, 2);
                end else begin
                    done_wait--;
                    if ($urandom_range(0, 3) == 0) bus.start = 1'b1;
                end
            end
        end

        check("cycle_budget", finished, 1);
        if (mode == MODE_ABORT) begin
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", bus.done, 0);
                check("abort_idle", bus.busy, 0);
            end
            check("abort_pc", bus.pc, 0);
        end else begin
            check("done_pulse", done_seen, exp_err ? 0 : 1);
            check("error", bus.error, exp_err);
            check("err_code", bus.err_code, exp_code);
            check("pc", bus.pc, exp_pc);
            check("all_dispatched", exp_q.size(), 0);
            check("all_read", addr_q.size(), 0);
            check("fill_cycles", fill_cnt, exp_fills * fill_lat);
            @(negedge clk);
            check("done_width", bus.done, 0);
            check("busy_after", bus.busy, 0);
        end
        bus.unit_done      = '0;
        bus.unit_ready     = '0;
        bus.imem_fill_done = 1'b0;
        bus.abort          = 1'b0;
    endtask

    task automatic wait_valid(input logic [NUM_UNITS-1:0] oh, input string tag);
        int cyc = 0;
        while (bus.instr_valid !== oh && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, bus.instr_valid, oh);
    endtask

    task automatic reset_mid_exec();
        mem[0] = mk_instr(1);
        mem[1] = mk_instr(2);
        @(negedge clk);
        bus.prog_len = (ADDR_W+1)'(2); bus.imem_empty = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(4'b0010, "rst_first_valid");
        bus.unit_ready = 4'b0010;
        @(negedge clk);
        bus.unit_ready = '0;
        bus.unit_done  = 4'b0010;
        @(negedge clk);
        bus.unit_done = '0;
        wait_valid(4'b0100, "rst_second_valid");
        bus.unit_ready = 4'b0100;
        @(negedge clk);
        bus.unit_ready = '0;
        @(negedge clk);
        check("rst_pre_busy", bus.busy, 1);
        check("rst_pre_pc", bus.pc, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int len, r;
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.prog_len       = '0;
        bus.imem_empty     = 1'b0;
        bus.imem_fill_done = 1'b0;
        bus.unit_ready     = '0;
        bus.unit_done      = '0;
        repeat (2) @(negedge clk);
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // three units in order
        for (int i = 0; i < 3; i++) mem[i] = mk_instr(i);
        run_prog(3, 1'b0, 1, MODE_NORMAL);

        // refill before the first read
        for (int i = 0; i < 4; i++) mem[i] = mk_instr($urandom_range(0, NUM_UNITS-1));
        run_prog(4, 1'b1, 10, MODE_NORMAL);

        // end-of-program marker at pc 1
        mem[0] = mk_instr(2); mem[1] = mk_instr(7); mem[2] = mk_instr(0); mem[3] = mk_instr(1);
        run_prog(4, 1'b0, 1, MODE_NORMAL);

        // illegal select, error held, then restart clears it
        mem[0] = mk_instr(5); mem[1] = mk_instr(0); mem[2] = mk_instr(1);
        run_prog(3, 1'b0, 1, MODE_NORMAL);
        repeat (3) begin
            @(negedge clk);
            check("err_held", bus.error, 1);
            check("err_code_held", bus.err_code, 2'b01);
        end
        mem[0] = mk_instr(3); mem[1] = mk_instr(0);
        run_prog(2, 1'b0, 1, MODE_NORMAL);

        // execution timeout
        mem[0] = mk_instr(3); mem[1] = mk_instr(1);
        run_prog(2, 1'b0, 1, MODE_NO_DONE);

        // abort while waiting for ready
        mem[0] = mk_instr(0); mem[1] = mk_instr(1); mem[2] = mk_instr(2);
        run_prog(3, 1'b0, 1, MODE_ABORT);

        // empty program
        run_prog(0, 1'b0, 1, MODE_NORMAL);

        reset_mid_exec();

        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      mem[i] = mk_instr(7);
                else if (r == 1) mem[i] = mk_instr($urandom_range(4, 6));
                else             mem[i] = mk_instr($urandom_range(0, NUM_UNITS-1));
            end
            run_prog(len, 1'($urandom_range(0, 1)), $urandom_range(1, 6), MODE_NORMAL);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
